// File: rtl/gray_counter_ctrl.sv
// Sequencing controller for a WIDTH-bit binary/Gray counter: load, step N times, pause/abort, done pulse.
// Optional wrap detection is built only when GRAY_CTRL_WRAP_DETECT_EN is defined; otherwise wrap is tied low.
module gray_counter_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] start_val,
   input  logic [CNT_W-1:0] num_steps,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             step_valid,
   output logic [WIDTH-1:0] binary_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_gray;
   logic [CNT_W-1:0] r_rem;
   logic             r_busy;
   logic             r_done;
   logic             r_aborted;
   logic             r_step_valid;

   logic [WIDTH-1:0] w_count_inc;
   logic [WIDTH-1:0] w_gray_inc;
   logic [WIDTH-1:0] w_gray_load;
   logic             w_accept;
   logic             w_advance;

   // Gray is computed from the value being loaded so both views update on the same edge.
   assign w_count_inc = r_count + WIDTH'(1);
   assign w_gray_inc  = w_count_inc ^ (w_count_inc >> 1);
   assign w_gray_load = start_val ^ (start_val >> 1);
   assign w_accept    = start & ~abort;
   assign w_advance   = ~pause & ~abort;

   // NOTE: every state register uses <= so all updates see pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_gray       <= '0;
         r_rem        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
         r_step_valid <= 1'b0;
      end else begin
         r_aborted    <= 1'b0;
         r_step_valid <= 1'b0;
         r_done       <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_count <= start_val;
                  r_gray  <= w_gray_load;
                  r_rem   <= num_steps;
                  if (num_steps == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state   <= ST_IDLE;
                  r_rem     <= '0;
                  r_busy    <= 1'b0;
                  r_aborted <= 1'b1;
               end else if (!pause) begin
                  r_count      <= w_count_inc;
                  r_gray       <= w_gray_inc;
                  r_rem        <= r_rem - CNT_W'(1);
                  r_step_valid <= 1'b1;
                  if (r_rem == CNT_W'(1)) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef GRAY_CTRL_WRAP_DETECT_EN
   logic r_wrap;

   // All-ones before an advance means this edge rolls the counter over to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_wrap <= 1'b0;
      else     r_wrap <= (r_state == ST_RUN) && w_advance && (&r_count);
   end

   assign wrap = r_wrap;
`else
   assign wrap = 1'b0;
`endif

   assign busy       = r_busy;
   assign done       = r_done;
   assign aborted    = r_aborted;
   assign step_valid = r_step_valid;
   assign binary_out = r_count;
   assign gray_out   = r_gray;

endmodule

// File: doc/gray_counter_ctrl.md
# gray_counter_ctrl

Sequencing controller for a WIDTH-bit binary/Gray counter. It loads a start value and advances the counter for a programmed number of steps. Pause and abort are supported, and completion is signalled with a one-cycle pulse. The block owns the count register and presents binary and Gray views of it. It sits between a host-side command interface and any logic consuming Gray-coded sequence values, such as pointer/phase generators.

## Interface
- `WIDTH`, 4: counter width in bits.
- `CNT_W`, 8: width of the step-count field.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `start_val` in WIDTH: binary value loaded on an accepted start.
- `num_steps` in CNT_W: number of increments to perform; captured on an accepted start.
- `pause` in 1: level; when high, RUN does not advance.
- `abort` in 1: terminates a run.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse (state DONE).
- `aborted` out 1: one-cycle pulse after an accepted abort.
- `step_valid` out 1: high for one cycle after each advancing edge.
- `binary_out` out WIDTH: registered count.
- `gray_out` out WIDTH: registered `count ^ (count >> 1)`; always consistent with `binary_out` in the same cycle.
- `wrap` out 1: see Configuration.

## Operation
- States are IDLE, RUN and DONE. The remaining-step register `rem` is CNT_W bits.
- **IDLE:**
  - `start=1` and `abort=0` at an edge: `count<=start_val`, `rem<=num_steps`.
  - Next state is RUN, or DONE if `num_steps==0`.
  - `start=1` together with `abort=1` is ignored; the block stays in IDLE and `aborted` does not pulse.
- **RUN, advancing edge** (`pause=0`, `abort=0`):
  - `count<=count+1` modulo 2^WIDTH, so all-ones wraps to 0.
  - `rem<=rem-1`.
  - If `rem==1` at this edge, next state is DONE; otherwise stay in RUN.
- **RUN, `pause=1`, `abort=0`:** `count` and `rem` hold; stay in RUN.
- **RUN, `abort=1`:** go to IDLE. `count` is retained, `rem` is cleared, and `aborted` pulses for the next cycle. Abort takes priority over pause.
- **DONE:** lasts exactly one cycle, then IDLE unconditionally. `start` and `abort` are ignored in this cycle.
- `start` in RUN or DONE is ignored; it is not queued.
- `binary_out` and `gray_out` hold their values in IDLE and DONE.

## Timing
- **Reset values:**
  - State IDLE.
  - `count=0`, `rem=0`.
  - `binary_out=0`, `gray_out=0`.
  - `busy=0`, `done=0`, `aborted=0`, `step_valid=0`, `wrap=0`.
- Reset asserted mid-run forces the reset values immediately, with no `done` or `aborted` pulse.
- Start accepted at edge E0: `busy=1` and `binary_out=start_val` after E0.
- With no pause, advances occur at edges E1..EN. After EN, `done=1`, `busy=0` and `binary_out=start_val+N` (mod 2^WIDTH).
- After E(N+1) the block is in IDLE. The earliest next start is accepted at E(N+2).
- `num_steps=0`: `done` pulses in the cycle after E0 and `count=start_val`.
- Each paused cycle in RUN delays `done` by exactly one cycle.
- `num_steps=2^CNT_W-1` is legal; there is no overflow, since `rem` only decrements.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro `GRAY_CTRL_WRAP_DETECT_EN` controls wrap detection.
- **Defined:** `wrap` pulses for one cycle after any advancing edge where `count` goes from 2^WIDTH-1 to 0. It pulses together with `step_valid`.
- **Undefined:** the `wrap` port is still present but tied to 0, and no detection logic is built.

## Test plan
- **Basic run:** reset, then `start_val=3`, `num_steps=5`, WIDTH=4.
  - `binary_out` goes 3,4,5,6,7,8.
  - Final `gray_out=4'b1100`.
  - `step_valid` high 5 times.
  - `done` pulses one cycle after the 5th advance; `busy` high for 5 cycles.
- **Wrap:** `start_val=14`, `num_steps=3`.
  - `binary_out` goes 14,15,0,1 and final `gray_out=4'b0001`.
  - With the macro, `wrap` pulses once, at the 15→0 step. Without it, `wrap` stays 0.
- **Pause:** `start_val=0`, `num_steps=4`, `pause=1` for 2 cycles after the 2nd advance.
  - `binary_out` holds at 2 for those cycles.
  - `done` arrives 2 cycles later than in the no-pause case; final value 4.
- **Abort priority:** `start_val=5`, `num_steps=10`; `abort=1` and `pause=1` together after 3 advances.
  - `aborted` pulses, no `done`, `binary_out` stays 8, state returns to IDLE.
  - A `start` in the same cycle as `abort` while in IDLE is ignored.
- **Zero steps and ignored start:**
  - `num_steps=0`, `start_val=9`: `done` pulses one cycle after the start edge, `binary_out=9`, `step_valid` never asserts.
  - A second `start` while in RUN does not alter `rem` or `count`.
- **Async reset mid-run:** assert `rst` between edges during RUN.
  - All outputs go to 0 immediately, with no `done` or `aborted` pulse.
  - A new start after reset release is accepted normally.
